mem_port_arbiter: RTL and testbench

//  Shares one unified single-port memory between the pipeline's instruction-fetch (IF) and data (MEM) requesters.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_arb_watchdog.sv | 37 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package mips_mem_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of IF, data-memory and external-memory handshake signals around the arbiter.
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_err;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              dm_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Wait-state counter for one memory access; expire_c_o flags the last permitted BUSY cycle.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds (cycles already waited); the TIMEOUT-th BUSY cycle sees TIMEOUT-1.
  assign expire_c_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access with a watchdog abort.
// Optional ARB_ROUND_ROBIN_EN: alternate grants under contention instead of fixed DM-over-IF priority.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q;
  logic              if_err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              dm_ack_q;
  logic              dm_err_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic              gnt_dm_c;
  logic              busy_c;
  logic              done_c;
  logic              wd_expire_c;
  logic              wd_clr_c;
  logic              wd_en_c;
  logic [DATA_W-1:0] resp_data_c;

`ifdef ARB_ROUND_ROBIN_EN
  grant_t            last_gnt_q;

  // Under contention grant whoever did not win last time.
  always_comb begin
    gnt_dm_c = bus.dm_req;
    if (bus.dm_req && bus.if_req) begin
      gnt_dm_c = (last_gnt_q == GNT_IF);
    end
  end
`else
  always_comb begin
    gnt_dm_c = bus.dm_req;
  end
`endif

  assign busy_c      = (state_q == BUSY_IF) || (state_q == BUSY_DM);
  assign done_c      = busy_c && (bus.mem_ack || wd_expire_c);
  assign wd_clr_c    = (state_q == IDLE);
  assign wd_en_c     = busy_c && !bus.mem_ack;
  assign resp_data_c = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (wd_clr_c),
    .en_i       (wd_en_c),
    .expire_c_o (wd_expire_c)
  );

  // Access sequencer; mem_ack takes precedence over expiry in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_ack_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q  <= GNT_IF;
`endif
    end else begin
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_ack_q   <= 1'b0;
      dm_err_q   <= 1'b0;
      dm_rdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (bus.dm_req || bus.if_req) begin
            state_q     <= gnt_dm_c ? BUSY_DM : BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= gnt_dm_c && bus.dm_we;
            mem_addr_q  <= gnt_dm_c ? bus.dm_addr : bus.if_addr;
            mem_wdata_q <= gnt_dm_c ? bus.dm_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt_q  <= gnt_dm_c ? GNT_DM : GNT_IF;
`endif
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (done_c) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (state_q == BUSY_DM) begin
              dm_ack_q   <= 1'b1;
              dm_err_q   <= !bus.mem_ack;
              dm_rdata_q <= resp_data_c;
            end else begin
              if_ack_q   <= 1'b1;
              if_err_q   <= !bus.mem_ack;
              if_rdata_q <= resp_data_c;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed literal checks followed by randomized traffic against a transaction-timeline model.
module tb_mem_port_arbiter;

  localparam int TB_TIMEOUT = 4;
  localparam int N_RAND     = 3000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model timeline: absolute cycle numbers of the current access
  int free_cyc, st_c, en_c, ack_c, w, b;
  logic who_dm, exp_err, exp_we, exp_req, in_busy, g_dm;
  logic [31:0] exp_addr, exp_wdata, exp_data;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm;
`endif

  // Requester agents
  logic pend_if, pend_dm, infl_if, infl_dm, we_dm;
  logic [31:0] a_if, a_dm, wd_dm;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d act=%b exp=%b", name, cyc, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;

    // Reset with if_req held
    repeat (2) @(negedge clk);
    chk1 ("rst_mem_req",  bus.mem_req,  1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk1 ("rst_if_ack",   bus.if_ack,   1'b0);
    chk1 ("rst_dm_ack",   bus.dm_ack,   1'b0);
    chk32("rst_if_rdata", bus.if_rdata, 32'h0);
    rst_n = 1'b1;

    // Zero-wait IF read at 0x40
    step(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8C010004;
    @(negedge clk);
    chk1 ("t1_mem_req",  bus.mem_req,  1'b1);
    chk32("t1_mem_addr", bus.mem_addr, 32'h40);
    chk1 ("t1_mem_we",   bus.mem_we,   1'b0);
    step(); bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    @(negedge clk);
    chk1 ("t2_if_ack",   bus.if_ack,   1'b1);
    chk32("t2_if_rdata", bus.if_rdata, 32'h8C010004);
    chk1 ("t2_if_err",   bus.if_err,   1'b0);
    chk1 ("t2_mem_req",  bus.mem_req,  1'b0);
    step(); bus.if_req = 1'b0;
    @(negedge clk);
    chk1 ("t2_if_ack_drop", bus.if_ack, 1'b0);

    // Simultaneous DM write and IF read: DM first
    step();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    step(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk1 ("t3_mem_req",   bus.mem_req,   1'b1);
    chk1 ("t3_mem_we",    bus.mem_we,    1'b1);
    chk32("t3_mem_addr",  bus.mem_addr,  32'h100);
    chk32("t3_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    step(); bus.mem_ack = 1'b0;
    @(negedge clk);
    chk1 ("t3_dm_ack",   bus.dm_ack,   1'b1);
    chk32("t3_dm_rdata", bus.dm_rdata, 32'h0);
    chk1 ("t3_dm_err",   bus.dm_err,   1'b0);
    chk1 ("t3_if_ack",   bus.if_ack,   1'b0);
    step(); bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    step(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    chk1 ("t3_if_mem_req", bus.mem_req,  1'b1);
    chk32("t3_if_addr",    bus.mem_addr, 32'h44);
    chk1 ("t3_if_we",      bus.mem_we,   1'b0);
    step(); bus.mem_ack = 1'b0;
    @(negedge clk);
    chk1 ("t3_if_ack2",  bus.if_ack,   1'b1);
    chk32("t3_if_rdata", bus.if_rdata, 32'h12345678);
    step(); bus.if_req = 1'b0;

    // Timeout: mem_ack never arrives
    step(); bus.dm_req = 1'b1; bus.dm_addr = 32'h200;
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      step();
      @(negedge clk);
      chk1("t5_mem_req_held", bus.mem_req, 1'b1);
    end
    step();
    @(negedge clk);
    chk1 ("t5_dm_ack",   bus.dm_ack,   1'b1);
    chk1 ("t5_dm_err",   bus.dm_err,   1'b1);
    chk32("t5_dm_rdata", bus.dm_rdata, 32'h0);
    chk1 ("t5_mem_req",  bus.mem_req,  1'b0);
    step(); bus.dm_req = 1'b0;
    @(negedge clk);
    chk1("t5_dm_ack_drop", bus.dm_ack, 1'b0);

    // mem_ack on the last allowed BUSY cycle wins over the timeout
    step(); bus.dm_req = 1'b1; bus.dm_addr = 32'h204;
    for (int i = 1; i <= TB_TIMEOUT; i++) begin
      step();
      if (i == TB_TIMEOUT) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5A5A5; end
      @(negedge clk);
      chk1("tb_mem_req_held", bus.mem_req, 1'b1);
    end
    step(); bus.mem_ack = 1'b0;
    @(negedge clk);
    chk1 ("tb_dm_ack",   bus.dm_ack,   1'b1);
    chk1 ("tb_dm_err",   bus.dm_err,   1'b0);
    chk32("tb_dm_rdata", bus.dm_rdata, 32'hA5A5A5A5);
    step(); bus.dm_req = 1'b0;

    // Reset in the middle of an access
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h80;
    step(); @(negedge clk); chk1("t6_busy1", bus.mem_req, 1'b1);
    step(); @(negedge clk); chk1("t6_busy2", bus.mem_req, 1'b1);
    step(); rst_n = 1'b0; bus.if_req = 1'b0;
    #1;
    chk1("t6_mem_req_async", bus.mem_req, 1'b0);
    chk1("t6_if_ack_async",  bus.if_ack,  1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); @(negedge clk);
      chk1("t6_no_ack_if",  bus.if_ack,  1'b0);
      chk1("t6_no_ack_dm",  bus.dm_ack,  1'b0);
      chk1("t6_no_mem_req", bus.mem_req, 1'b0);
    end

    // Randomized traffic
    cyc = 0; free_cyc = 0; st_c = -100; en_c = -100; ack_c = -100; w = 1; b = 1;
    who_dm = 1'b0; exp_err = 1'b0; exp_we = 1'b0; g_dm = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_data = '0;
`ifdef ARB_ROUND_ROBIN_EN
    last_dm = 1'b0;
`endif
    pend_if = 1'b0; pend_dm = 1'b0; infl_if = 1'b0; infl_dm = 1'b0;
    we_dm = 1'b0; a_if = '0; a_dm = '0; wd_dm = '0;

    for (int k = 0; k < N_RAND; k++) begin
      step();
      if (cyc == ack_c + 1) begin
        if (who_dm) pend_dm = 1'b0; else pend_if = 1'b0;
        infl_if = 1'b0; infl_dm = 1'b0;
      end
      if (!pend_if && $urandom_range(3) != 0) begin
        pend_if = 1'b1; a_if = $urandom;
      end
      if (!pend_dm && $urandom_range(3) != 0) begin
        pend_dm = 1'b1; we_dm = 1'($urandom_range(1)); a_dm = $urandom; wd_dm = $urandom;
      end
      // An in-flight requester may drop req; that must not disturb the access
      bus.if_req   = infl_if ? 1'($urandom_range(1)) : pend_if;
      bus.if_addr  = a_if;
      bus.dm_req   = infl_dm ? 1'($urandom_range(1)) : pend_dm;
      bus.dm_we    = we_dm;
      bus.dm_addr  = a_dm;
      bus.dm_wdata = wd_dm;
      bus.mem_rdata = $urandom;
      in_busy = (cyc >= st_c) && (cyc <= en_c);
      bus.mem_ack = in_busy ? (cyc == st_c + w - 1) : ($urandom_range(3) == 0);
      if (in_busy && bus.mem_ack && !exp_we) exp_data = bus.mem_rdata;

      if (cyc >= free_cyc && (bus.if_req || bus.dm_req)) begin
        if (bus.if_req && bus.dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          g_dm = !last_dm;
`else
          g_dm = 1'b1;
`endif
        end else begin
          g_dm = bus.dm_req;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_dm = g_dm;
`endif
        who_dm   = g_dm;
        w        = int'($urandom_range(TB_TIMEOUT + 2, 1));
        b        = (w <= TB_TIMEOUT) ? w : TB_TIMEOUT;
        st_c     = cyc + 1;
        en_c     = cyc + b;
        ack_c    = en_c + 1;
        free_cyc = ack_c + 1;
        exp_err  = (w > TB_TIMEOUT);
        exp_we   = g_dm && we_dm;
        exp_addr = g_dm ? a_dm : a_if;
        exp_wdata = wd_dm;
        exp_data = '0;
        if (g_dm) infl_dm = 1'b1; else infl_if = 1'b1;
      end

      @(negedge clk);
      exp_req = (cyc >= st_c) && (cyc <= en_c);
      chk1("r_mem_req", bus.mem_req, exp_req);
      if (exp_req) begin
        chk1 ("r_mem_we",   bus.mem_we,   exp_we);
        chk32("r_mem_addr", bus.mem_addr, exp_addr);
        if (exp_we) chk32("r_mem_wdata", bus.mem_wdata, exp_wdata);
      end
      chk1("r_if_ack", bus.if_ack, (cyc == ack_c) && !who_dm);
      chk1("r_dm_ack", bus.dm_ack, (cyc == ack_c) && who_dm);
      if (cyc == ack_c) begin
        if (who_dm) begin
          chk1 ("r_dm_err",   bus.dm_err,   exp_err);
          chk32("r_dm_rdata", bus.dm_rdata, exp_data);
        end else begin
          chk1 ("r_if_err",   bus.if_err,   exp_err);
          chk32("r_if_rdata", bus.if_rdata, exp_data);
        end
      end
      cyc++;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
